// File: rtl/mem_wb_stage_if.sv
// Bus bundle for mem_wb_stage: execute-side handshake, data-memory port,
// register-file write port and exception signals.
interface mem_wb_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [31:0] in_result;
   logic [31:0] in_store_data;
   logic        in_alu_err;
   logic        in_wb_en;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic        retire;
   logic        exc;
   logic [1:0]  exc_code;
   logic        exc_clear;

   // Environment side: execute stage, memory and exception controller.
   modport master (
      output in_valid, in_opcode, in_rd, in_result, in_store_data, in_alu_err, in_wb_en,
      output mem_ack, mem_rdata, exc_clear,
      input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
      input  rf_we, rf_waddr, rf_wdata, retire, exc, exc_code
   );

   // Stage side.
   modport slave (
      input  in_valid, in_opcode, in_rd, in_result, in_store_data, in_alu_err, in_wb_en,
      input  mem_ack, mem_rdata, exc_clear,
      output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
      output rf_we, rf_waddr, rf_wdata, retire, exc, exc_code
   );
endinterface

// File: rtl/mem_wb_stage.sv
// Execute-to-writeback stage: one instruction at a time, lw/sw over a req/ack
// memory port, register-file writeback and a sticky exception.
// Optional feature: define MEM_TIMEOUT_EN to abort memory accesses that wait
// TIMEOUT_CYCLES cycles without an ack (exception code 11).
module mem_wb_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_wb_stage_if.slave bus
);

   localparam logic [5:0] OpLw = 6'b100011;
   localparam logic [5:0] OpSw = 6'b101011;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMem  = 2'd1;
   localparam logic [1:0] StWb   = 2'd2;
   localparam logic [1:0] StExc  = 2'd3;

   localparam logic [1:0] ExcNone     = 2'b00;
   localparam logic [1:0] ExcOverflow = 2'b01;
   localparam logic [1:0] ExcMisalign = 2'b10;
`ifdef MEM_TIMEOUT_EN
   localparam logic [1:0] ExcTimeout  = 2'b11;
`endif

   logic [1:0]  state_q, state_d;
   logic [1:0]  code_q, code_d;
   logic        ready_q;
   logic        sw_retire_q, sw_done;
   logic [5:0]  op_q;
   logic [4:0]  rd_q;
   logic [31:0] data_q;     // ALU result / address, replaced by load data on lw ack
   logic [31:0] wdata_q;
   logic        wb_en_q;

   logic accept;
   logic in_is_mem;
   logic is_lw_q, is_sw_q;

   assign accept    = bus.in_valid && ready_q;
   assign in_is_mem = (bus.in_opcode == OpLw) || (bus.in_opcode == OpSw);
   assign is_lw_q   = (op_q == OpLw);
   assign is_sw_q   = (op_q == OpSw);

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt_q;
   logic            timeout;

   // Count MEM cycles without ack; zero whenever not in MEM so each entry starts fresh.
   always_ff @(posedge clk) begin
      if (!rst_n || state_q != StMem) begin
         cnt_q <= '0;
      end else if (!bus.mem_ack) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

   // Next-state and exception-code decode.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      sw_done = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (bus.in_alu_err) begin
                  state_d = StExc;
                  code_d  = ExcOverflow;
               end else if (in_is_mem && bus.in_result[1:0] != 2'b00) begin
                  state_d = StExc;
                  code_d  = ExcMisalign;
               end else if (in_is_mem) begin
                  state_d = StMem;
               end else begin
                  state_d = StWb;
               end
            end
         end
         StMem: begin
            // An ack on the limit edge wins over the timeout.
            if (bus.mem_ack) begin
               if (is_lw_q) begin
                  state_d = StWb;
               end else begin
                  state_d = StIdle;
                  sw_done = 1'b1;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (timeout) begin
               state_d = StExc;
               code_d  = ExcTimeout;
            end
`endif
         end
         StWb: begin
            state_d = StIdle;
         end
         StExc: begin
            if (bus.exc_clear) begin
               state_d = StIdle;
               code_d  = ExcNone;
            end
         end
         default: begin
            state_d = StIdle;
            code_d  = ExcNone;
         end
      endcase
   end

   // Control state; in_ready is registered so it stays low through reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         code_q      <= ExcNone;
         ready_q     <= 1'b0;
         sw_retire_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         ready_q     <= (state_d == StIdle);
         sw_retire_q <= sw_done;
      end
   end

   // Instruction fields captured on accept; load data overwrites the result on lw ack.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q    <= '0;
         rd_q    <= '0;
         data_q  <= '0;
         wdata_q <= '0;
         wb_en_q <= 1'b0;
      end else if (state_q == StIdle && accept) begin
         op_q    <= bus.in_opcode;
         rd_q    <= bus.in_rd;
         data_q  <= bus.in_result;
         wdata_q <= bus.in_store_data;
         wb_en_q <= bus.in_wb_en;
      end else if (state_q == StMem && bus.mem_ack && is_lw_q) begin
         data_q  <= bus.mem_rdata;
      end
   end

   // Outputs decoded from state and registered fields only.
   always_comb begin
      bus.in_ready  = ready_q;
      bus.mem_req   = (state_q == StMem);
      bus.mem_we    = (state_q == StMem) && is_sw_q;
      bus.mem_addr  = (state_q == StMem) ? data_q : '0;
      bus.mem_wdata = (state_q == StMem) ? wdata_q : '0;
      bus.rf_we     = (state_q == StWb) && wb_en_q && (rd_q != '0);
      bus.rf_waddr  = (state_q == StWb) ? rd_q : '0;
      bus.rf_wdata  = (state_q == StWb) ? data_q : '0;
      bus.retire    = (state_q == StWb) || sw_retire_q;
      bus.exc       = (state_q == StExc);
      bus.exc_code  = code_q;
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: every cycle's outputs are compared
// against a transaction-level expectation built from the stage's rules.
module tb_mem_wb_stage;

   localparam int unsigned TO = 4;
   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_wb_stage_if bus ();

   mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic        ready;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] rf_wdata;
      logic        retire;
      logic        exc;
      logic [1:0]  code;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   bit   retire_next = 1'b0;

   // Observation log used by the literal checks.
   int          req_cycles, rf_we_cnt, retire_cnt;
   logic [4:0]  last_waddr;
   logic [31:0] last_wdata;
   logic [1:0]  last_code;

   function automatic obs_t observe();
      obs_t o;
      o.ready    = bus.in_ready;
      o.req      = bus.mem_req;
      o.we       = bus.mem_we;
      o.addr     = bus.mem_addr;
      o.wdata    = bus.mem_wdata;
      o.rf_we    = bus.rf_we;
      o.waddr    = bus.rf_waddr;
      o.rf_wdata = bus.rf_wdata;
      o.retire   = bus.retire;
      o.exc      = bus.exc;
      o.code     = bus.exc_code;
      return o;
   endfunction

   // Compare process: one full output vector per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      obs_t act, e;
      cyc++;
      act = observe();
      if (act.req === 1'b1) req_cycles++;
      if (act.rf_we === 1'b1) begin
         rf_we_cnt++;
         last_waddr = act.waddr;
         last_wdata = act.rf_wdata;
      end
      if (act.retire === 1'b1) retire_cnt++;
      if (act.exc === 1'b1) last_code = act.code;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (act === e) n_pass++;
         else $display("FAIL cycle %0d outputs: got %h want %h", cyc, act, e);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   task automatic clr_log();
      req_cycles = 0;
      rf_we_cnt  = 0;
      retire_cnt = 0;
      last_waddr = '0;
      last_wdata = '0;
      last_code  = '0;
   endtask

   task automatic step(input obs_t e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic obs_t idle_o();
      obs_t o;
      o        = '0;
      o.ready  = 1'b1;
      o.retire = retire_next;
      return o;
   endfunction

   // Garbage on the execute side while the stage is busy; must not be accepted.
   task automatic scramble();
      bus.in_valid      = 1'($urandom);
      bus.in_opcode     = 6'($urandom);
      bus.in_rd         = 5'($urandom);
      bus.in_result     = $urandom;
      bus.in_store_data = $urandom;
      bus.in_alu_err    = 1'($urandom);
      bus.in_wb_en      = 1'($urandom);
   endtask

   task automatic idle_cycle();
      obs_t e;
      bus.in_valid  = 1'b0;
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = $urandom;
      bus.exc_clear = 1'($urandom);
      e = idle_o();
      retire_next = 1'b0;
      step(e);
   endtask

   task automatic exc_phase(input logic [1:0] code, input int hold);
      obs_t e;
      e      = '0;
      e.exc  = 1'b1;
      e.code = code;
      for (int i = 0; i < hold; i++) begin
         scramble();
         bus.mem_ack   = 1'($urandom);
         bus.exc_clear = 1'b0;
         step(e);
      end
      scramble();
      bus.exc_clear = 1'b1;
      step(e);
      bus.exc_clear = 1'b0;
      bus.in_valid  = 1'b0;
   endtask

   task automatic wb_phase(input logic [4:0] rd, input logic [31:0] data, input logic wb_en);
      obs_t e;
      scramble();
      bus.mem_ack   = 1'($urandom);
      bus.exc_clear = 1'($urandom);
      e          = '0;
      e.rf_we    = wb_en && (rd != 5'd0);
      e.waddr    = rd;
      e.rf_wdata = data;
      e.retire   = 1'b1;
      step(e);
      bus.in_valid = 1'b0;
   endtask

   // One instruction: accept cycle, then exception, memory and writeback phases.
   task automatic do_instr(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] res,
                           input logic [31:0] sd, input logic alu_err, input logic wb_en,
                           input int delay, input logic [31:0] rdata, input int hold);
      obs_t e;
      logic [1:0] code;
      bit is_mem;
      int i;
      is_mem = (op == OP_LW) || (op == OP_SW);
      bus.in_valid      = 1'b1;
      bus.in_opcode     = op;
      bus.in_rd         = rd;
      bus.in_result     = res;
      bus.in_store_data = sd;
      bus.in_alu_err    = alu_err;
      bus.in_wb_en      = wb_en;
      bus.mem_ack       = 1'($urandom);
      bus.mem_rdata     = $urandom;
      bus.exc_clear     = 1'($urandom);
      e = idle_o();
      retire_next = 1'b0;
      step(e);

      code = alu_err ? 2'b01 : (is_mem && res[1:0] != 2'b00) ? 2'b10 : 2'b00;
      if (code != 2'b00) begin
         exc_phase(code, hold);
         return;
      end
      if (!is_mem) begin
         wb_phase(rd, res, wb_en);
         return;
      end
      i = 0;
      while (1) begin
`ifdef MEM_TIMEOUT_EN
         if (i == int'(TO)) begin
            exc_phase(2'b11, hold);
            return;
         end
`endif
         scramble();
         bus.mem_ack   = (i == delay);
         bus.mem_rdata = (i == delay) ? rdata : $urandom;
         bus.exc_clear = 1'($urandom);
         e       = '0;
         e.req   = 1'b1;
         e.we    = (op == OP_SW);
         e.addr  = res;
         e.wdata = sd;
         step(e);
         if (i == delay) break;
         i++;
      end
      bus.mem_ack = 1'b0;
      if (op == OP_SW) begin
         bus.in_valid = 1'b0;
         retire_next  = 1'b1;
      end else begin
         wb_phase(rd, rdata, wb_en);
      end
   endtask

   initial begin
      obs_t e;
      logic [5:0]  op;
      logic [31:0] res;
      bus.in_valid      = 1'b0;
      bus.in_opcode     = '0;
      bus.in_rd         = '0;
      bus.in_result     = '0;
      bus.in_store_data = '0;
      bus.in_alu_err    = 1'b0;
      bus.in_wb_en      = 1'b0;
      bus.mem_ack       = 1'b0;
      bus.mem_rdata     = '0;
      bus.exc_clear     = 1'b0;
      clr_log();

      // Reset: all outputs zero, in_ready low until after release.
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) step('0);
      rst_n = 1'b1;
      step('0);
      idle_cycle();

      // Add writeback.
      clr_log();
      do_instr(6'b000000, 5'd5, 32'h7, 32'h0, 1'b0, 1'b1, 0, 32'h0, 0);
      idle_cycle();
      chk("add_waddr", 32'(last_waddr), 32'd5);
      chk("add_wdata", last_wdata, 32'h7);
      chk("add_retire", 32'(retire_cnt), 32'd1);

      // Load with ack in third MEM cycle.
      clr_log();
      do_instr(OP_LW, 5'd3, 32'h10, 32'h0, 1'b0, 1'b1, 2, 32'hDEAD_BEEF, 0);
      idle_cycle();
      chk("lw_req_cycles", 32'(req_cycles), 32'd3);
      chk("lw_wdata", last_wdata, 32'hDEAD_BEEF);

      // Store to rd 0: retires, never writes.
      clr_log();
      do_instr(OP_SW, 5'd0, 32'h20, 32'h1234_5678, 1'b0, 1'b1, 1, 32'h0, 0);
      idle_cycle();
      chk("sw_retire", 32'(retire_cnt), 32'd1);
      chk("sw_no_rf_we", 32'(rf_we_cnt), 32'd0);

      // Overflow, then a normal add.
      clr_log();
      do_instr(6'b000000, 5'd9, 32'h55, 32'h0, 1'b1, 1'b1, 0, 32'h0, 3);
      chk("ovf_code", 32'(last_code), 32'd1);
      chk("ovf_no_rf_we", 32'(rf_we_cnt), 32'd0);
      do_instr(6'b000000, 5'd9, 32'h99, 32'h0, 1'b0, 1'b1, 0, 32'h0, 0);
      idle_cycle();
      chk("post_clear_wdata", last_wdata, 32'h99);

      // Misaligned store.
      clr_log();
      do_instr(OP_SW, 5'd1, 32'h6, 32'hAA, 1'b0, 1'b0, 0, 32'h0, 1);
      chk("misal_code", 32'(last_code), 32'd2);
      chk("misal_no_req", 32'(req_cycles), 32'd0);

      // Memory that never acks in time.
      clr_log();
`ifdef MEM_TIMEOUT_EN
      do_instr(OP_LW, 5'd4, 32'h40, 32'h0, 1'b0, 1'b1, 1000, 32'h0, 1);
      chk("timeout_req_cycles", 32'(req_cycles), 32'd4);
      chk("timeout_code", 32'(last_code), 32'd3);
      chk("timeout_no_rf_we", 32'(rf_we_cnt), 32'd0);
`else
      do_instr(OP_LW, 5'd4, 32'h40, 32'h0, 1'b0, 1'b1, 99, 32'hCAFE_0001, 1);
      chk("long_wait_req_cycles", 32'(req_cycles), 32'd100);
      chk("long_wait_wdata", last_wdata, 32'hCAFE_0001);
`endif
      idle_cycle();

      // Reset during MEM; late ack must be ignored.
      clr_log();
      bus.in_valid      = 1'b1;
      bus.in_opcode     = OP_LW;
      bus.in_rd         = 5'd7;
      bus.in_result     = 32'h80;
      bus.in_store_data = 32'h0;
      bus.in_alu_err    = 1'b0;
      bus.in_wb_en      = 1'b1;
      bus.mem_ack       = 1'b0;
      step(idle_o());
      bus.in_valid = 1'b0;
      e      = '0;
      e.req  = 1'b1;
      e.addr = 32'h80;
      step(e);
      rst_n = 1'b0;
      step(e);
      rst_n       = 1'b1;
      bus.mem_ack = 1'b1;
      step('0);
      bus.mem_ack = 1'b0;
      idle_cycle();
      idle_cycle();
      chk("rst_no_rf_we", 32'(rf_we_cnt), 32'd0);
      chk("rst_no_retire", 32'(retire_cnt), 32'd0);

      // Randomized instruction stream.
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 2))
            0:       op = OP_LW;
            1:       op = OP_SW;
            default: op = 6'($urandom);
         endcase
         res = $urandom;
         if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
         do_instr(op, 5'($urandom), res, $urandom, ($urandom_range(0, 7) == 0),
                  1'($urandom), $urandom_range(0, 6), $urandom, $urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();
      idle_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Execute-to-writeback stage of the multi-cycle CPU: consumes the ALU result and overflow flag for one instruction at a time, performs the data-memory access for `lw`/`sw` over a request/acknowledge handshake, and writes the final value into the register file. It also converts ALU overflow, misaligned addresses and (optionally) memory timeouts into a sticky exception that stalls the core until software clears it.

## Interface
- `TIMEOUT_CYCLES`, 16: memory wait limit in cycles; used only with `MEM_TIMEOUT_EN`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  execute stage presents an instruction.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_opcode`  in  6  instruction opcode.
- `in_rd`  in  5  destination register number.
- `in_result`  in  32  ALU result; this is the byte address for `lw`/`sw`.
- `in_store_data`  in  32  rs2 value; this is the store data for `sw`.
- `in_alu_err`  in  1  ALU overflow/illegal flag.
- `in_wb_en`  in  1  instruction writes a register.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = store, 0 = load.
- `mem_addr`  out  32  word-aligned byte address.
- `mem_wdata`  out  32  store data.
- `mem_ack`  in  1  memory completes the request this cycle.
- `mem_rdata`  in  32  load data; valid when `mem_ack` = 1.
- `rf_we`  out  1  register-file write strobe.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `exc`  out  1  sticky exception flag.
- `exc_code`  out  2  exception cause: 01 = overflow, 10 = misaligned, 11 = timeout, 00 = none.
- `exc_clear`  in  1  clears the exception.

## Operation
- **FSM states:** IDLE, MEM, WB, EXC.
- **IDLE**
  - `in_ready` = 1.
  - Accepts on `in_valid & in_ready` and registers all `in_*` fields.
  - If `in_alu_err` = 1: go to EXC with code 01.
  - Else if opcode is `lw` (100011) or `sw` (101011) and `in_result[1:0]` != 0: go to EXC with code 10.
  - Else if opcode is `lw` or `sw`: go to MEM.
  - Else: go to WB.
- **MEM**
  - `mem_req` = 1; `mem_we` = 1 for `sw`.
  - `mem_addr` and `mem_wdata` are held stable until the ack.
  - On `mem_ack` with `lw`: capture `mem_rdata`, go to WB.
  - On `mem_ack` with `sw`: pulse `retire`, go to IDLE.
  - `mem_ack` outside MEM is ignored.
- **WB**
  - `rf_we` = `wb_en & (rd != 0)`.
  - `rf_wdata` = loaded data for `lw`, otherwise the ALU result.
  - `retire` = 1; go to IDLE.
- **EXC**
  - `exc` = 1 and `in_ready` = 0.
  - No register or memory side effects for the faulting instruction.
  - `exc_clear` = 1 returns the FSM to IDLE and clears `exc` and `exc_code` at that edge.
- **Widths:** no arithmetic beyond the alignment check; all data paths are 32-bit pass-through.
- **Reset value of every output:** `in_ready` = 0 while `rst_n` = 0, 1 from the first cycle after release. All other outputs are 0 during reset: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `rf_we`, `rf_waddr`, `rf_wdata`, `retire`, `exc`, `exc_code`.
- **Reset mid-operation:** reset in MEM drops `mem_req` at that edge and abandons the access. A late `mem_ack` is then ignored.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from `in_*` to the outputs.
- **ALU instruction:** accepted at edge N; `rf_we` and `retire` high in cycle N+1; `in_ready` high again in cycle N+2. Throughput is one instruction per 2 cycles.
- **Memory access:** accepted at edge N; `mem_req` high from cycle N+1.
  - Ack sampled at edge M: `mem_req` low from M+1.
  - `lw`: WB in cycle M+1.
  - `sw`: `retire` in cycle M+1.
- **Zero-wait memory:** an ack in the first MEM cycle is legal. `lw` then writes back 2 cycles after acceptance.
- **Exceptions:** `exc` is high from the cycle after the faulting edge.
- **Simultaneous events:** `exc_clear` asserted outside EXC has no effect. `in_valid` while `in_ready` = 0 is not accepted, and the upstream stage must hold the instruction.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - A counter counts MEM cycles without `mem_ack`.
  - When it reaches `TIMEOUT_CYCLES`: `mem_req` drops, FSM goes to EXC with code 11, no register write.
  - An ack on the same edge as the limit wins; no timeout is raised.
  - The counter resets on every entry to MEM.
- **`MEM_TIMEOUT_EN` not defined:** no counter; MEM waits indefinitely and code 11 never occurs.

## Test plan
- **Add writeback:** `in_opcode`=000000, `rd`=5, `result`=0x0000_0007, `wb_en`=1 -> next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=7, `retire`=1.
- **Load with wait states:** `lw`, addr 0x10, ack after 3 cycles with `rdata`=0xDEAD_BEEF -> `mem_req` high exactly 3 cycles, `mem_we`=0, then `rf_wdata`=0xDEAD_BEEF. A store to `rd`=0 shows `mem_we`=1 and `retire`, with no `rf_we`.
- **Overflow:** `in_alu_err`=1 -> `exc`=1, `exc_code`=01, `rf_we` never set, `in_ready`=0 until `exc_clear`. After the clear, the next add completes normally.
- **Misaligned access:** `sw` with addr 0x0000_0006 -> `exc_code`=10, `mem_req` never asserted.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** `lw` with no ack -> `mem_req` high 4 cycles, then `exc_code`=11. Without the macro, `mem_req` stays high for 100 cycles.
- **Reset during MEM:** `rst_n` low during MEM -> all outputs 0 at that edge; an ack arriving afterwards causes no write and no `retire`.
